gcm_phase_sequencer: RTL and testbench

GCM_PHASE_SEQUENCER -- requirements
Module: gcm_phase_sequencer

---
 rtl/gcm_phase_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_gcm_phase_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcm_phase_sequencer
// Purpose  : Steps one GCM instance through its phases (hash-key derivation,
//            AAD blocks, text blocks, length block), tags every beat issued to
//            the AES pipeline with its phase and running block index, then
//            waits for the pipeline to drain and pulses o_done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PIPE_LATENCY    cycles from a beat entering the AES pipeline to its result
//   CNT_W           width of the internal block counters (<= 64)
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   i_start         one-cycle request to begin an instance (honoured in IDLE)
//   i_instance_size [0:63] AAD length in bits, [64:127] text length in bits
//   i_blk_valid     upstream AAD/text block available
//   o_blk_ready     sequencer accepts a block this cycle (AAD/TEXT only)
//   o_valid         a beat is issued to the pipeline this cycle
//   o_phase         phase tag (IDLE 0, HKEY 1, AAD 2, TEXT 3, LEN 4,
//                   DRAIN 5, DONE 6)
//   o_counter       running block index; upper half zero
//   o_new_instance  first beat (HKEY) of an instance
//   o_instance_size latched i_instance_size
//   o_busy          instance in progress
//   o_done          one-cycle pulse after the last beat has left the pipeline
//   o_last_bits     valid bits of the final partial block of the phase
// Configuration macro
//   GCM_SEQ_PARTIAL_BLOCK_EN  defined: block counts round up and o_last_bits
//                             reports the trailing bit count on the final beat
//                             of each phase; undefined: block counts round
//                             down, trailing bits ignored, o_last_bits = 0
// ============================================================================
module gcm_phase_sequencer #(
    parameter int PIPE_LATENCY = 12,
    parameter int CNT_W        = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [0:127] i_instance_size,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    output logic         o_valid,
    output logic [0:2]   o_phase,
    output logic [0:127] o_counter,
    output logic         o_new_instance,
    output logic [0:127] o_instance_size,
    output logic         o_busy,
    output logic         o_done,
    output logic [0:6]   o_last_bits
);

    localparam logic [2:0] c_IDLE  = 3'b000;
    localparam logic [2:0] c_HKEY  = 3'b001;
    localparam logic [2:0] c_AAD   = 3'b010;
    localparam logic [2:0] c_TEXT  = 3'b011;
    localparam logic [2:0] c_LEN   = 3'b100;
    localparam logic [2:0] c_DRAIN = 3'b101;
    localparam logic [2:0] c_DONE  = 3'b110;

    // The drain counter only has to hold PIPE_LATENCY-1.
    localparam int                     c_DRAIN_W    = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [c_DRAIN_W-1:0]   c_DRAIN_LOAD = c_DRAIN_W'((PIPE_LATENCY > 1) ? PIPE_LATENCY - 1 : 0);
    localparam logic [c_DRAIN_W-1:0]   c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam bit                     c_HAS_DRAIN  = (PIPE_LATENCY > 1);
    localparam logic [CNT_W-1:0]       c_CNT_ONE    = CNT_W'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [0:127]         r_size;
    logic [CNT_W-1:0]     r_counter;
    logic [CNT_W-1:0]     r_aad_blks;
    logic [CNT_W-1:0]     r_txt_blks;
    logic [c_DRAIN_W-1:0] r_drain;

    logic [63:0]          w_aad_bits;
    logic [63:0]          w_txt_bits;
    logic [CNT_W-1:0]     w_aad_blks_in;
    logic [CNT_W-1:0]     w_txt_blks_in;
    logic                 w_blk_ready;
    logic                 w_beat;
    logic                 w_aad_last;
    logic                 w_txt_last;

    assign w_aad_bits = i_instance_size[0:63];
    assign w_txt_bits = i_instance_size[64:127];

`ifdef GCM_SEQ_PARTIAL_BLOCK_EN
    // A trailing partial block still costs a full beat.
    assign w_aad_blks_in = CNT_W'(w_aad_bits >> 7) + ((|w_aad_bits[6:0]) ? c_CNT_ONE : '0);
    assign w_txt_blks_in = CNT_W'(w_txt_bits >> 7) + ((|w_txt_bits[6:0]) ? c_CNT_ONE : '0);
`else
    assign w_aad_blks_in = CNT_W'(w_aad_bits >> 7);
    assign w_txt_blks_in = CNT_W'(w_txt_bits >> 7);
`endif

    assign w_blk_ready = (r_state == c_AAD) || (r_state == c_TEXT);
    assign w_beat      = w_blk_ready && i_blk_valid;

    // AAD occupies counter values 0..A-1 and TEXT continues at A..A+T-1, so
    // the final beat of each phase is recognised from the shared counter.
    assign w_aad_last  = (r_counter == r_aad_blks - c_CNT_ONE);
    assign w_txt_last  = (r_counter == r_aad_blks + r_txt_blks - c_CNT_ONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_start) begin
                    w_state_nxt = c_HKEY;
                end
            end
            c_HKEY: begin
                if (r_aad_blks != '0) begin
                    w_state_nxt = c_AAD;
                end else if (r_txt_blks != '0) begin
                    w_state_nxt = c_TEXT;
                end else begin
                    w_state_nxt = c_LEN;
                end
            end
            c_AAD: begin
                if (w_beat && w_aad_last) begin
                    w_state_nxt = (r_txt_blks != '0) ? c_TEXT : c_LEN;
                end
            end
            c_TEXT: begin
                if (w_beat && w_txt_last) begin
                    w_state_nxt = c_LEN;
                end
            end
            c_LEN: begin
                w_state_nxt = c_HAS_DRAIN ? c_DRAIN : c_DONE;
            end
            c_DRAIN: begin
                // Leave on the cycle the decrement reaches zero, so DONE lands
                // exactly PIPE_LATENCY cycles after the LEN beat.
                if (r_drain <= c_DRAIN_ONE) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_size     <= '0;
            r_counter  <= '0;
            r_aad_blks <= '0;
            r_txt_blks <= '0;
            r_drain    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_IDLE) && i_start) begin
                r_size     <= i_instance_size;
                r_aad_blks <= w_aad_blks_in;
                r_txt_blks <= w_txt_blks_in;
                r_counter  <= '0;
            end else if (w_beat) begin
                // Wraps silently modulo 2^CNT_W.
                r_counter <= r_counter + c_CNT_ONE;
            end
            if (r_state == c_LEN) begin
                r_drain <= c_DRAIN_LOAD;
            end else if (r_state == c_DRAIN) begin
                r_drain <= r_drain - c_DRAIN_ONE;
            end
        end
    end

    assign o_phase         = r_state;
    assign o_blk_ready     = w_blk_ready;
    assign o_valid         = (r_state == c_HKEY) || (r_state == c_LEN) || w_beat;
    assign o_new_instance  = (r_state == c_HKEY);
    assign o_counter       = {64'd0, 64'(r_counter)};
    assign o_instance_size = r_size;
    assign o_busy          = (r_state != c_IDLE);
    assign o_done          = (r_state == c_DONE);

`ifdef GCM_SEQ_PARTIAL_BLOCK_EN
    always_comb begin
        o_last_bits = '0;
        if (w_beat && (r_state == c_AAD) && w_aad_last) begin
            o_last_bits = r_size[57:63];
        end else if (w_beat && (r_state == c_TEXT) && w_txt_last) begin
            o_last_bits = r_size[121:127];
        end
    end
`else
    assign o_last_bits = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcm_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcm_phase_sequencer
// Purpose  : Scoreboard bench for gcm_phase_sequencer. A driver plans each
//            instance from its AAD/text bit lengths into a queue of expected
//            beats; a monitor pops and compares on every issued beat, checks
//            the o_done timing and the reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcm_phase_sequencer;

    localparam int PIPE_LATENCY = 12;
    localparam int CNT_W        = 64;
    localparam int GUARD_CYCLES = 3000;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_HKEY = 3'd1;
    localparam logic [2:0] PH_AAD  = 3'd2;
    localparam logic [2:0] PH_TEXT = 3'd3;
    localparam logic [2:0] PH_LEN  = 3'd4;
    localparam logic [2:0] PH_DONE = 3'd6;

    typedef struct packed {
        logic [2:0]   ph;
        logic [127:0] cnt;
        logic         nw;
        logic [6:0]   lb;
        logic [127:0] sz;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [0:127] i_instance_size = '0;
    logic         i_blk_valid = 1'b0;
    logic         o_blk_ready;
    logic         o_valid;
    logic [0:2]   o_phase;
    logic [0:127] o_counter;
    logic         o_new_instance;
    logic [0:127] o_instance_size;
    logic         o_busy;
    logic         o_done;
    logic [0:6]   o_last_bits;

    beat_t exp_q[$];
    int    errors    = 0;
    int    checks    = 0;
    int    n_started = 0;
    int    n_closed  = 0;
    int    to_cnt    = 0;
    int    seen_to   = 0;
    int    cyc       = 0;
    int    len_cyc   = 0;

    gcm_phase_sequencer #(
        .PIPE_LATENCY (PIPE_LATENCY),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_instance_size (i_instance_size),
        .i_blk_valid     (i_blk_valid),
        .o_blk_ready     (o_blk_ready),
        .o_valid         (o_valid),
        .o_phase         (o_phase),
        .o_counter       (o_counter),
        .o_new_instance  (o_new_instance),
        .o_instance_size (o_instance_size),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_last_bits     (o_last_bits)
    );

    always #5 clk = ~clk;

    // Number of 128-bit blocks a phase of the given bit length occupies.
    function automatic longint unsigned blocks(input longint unsigned bits);
`ifdef GCM_SEQ_PARTIAL_BLOCK_EN
        return (bits + 127) / 128;
`else
        return bits / 128;
`endif
    endfunction

    // Expected beat list of one instance: HKEY, A AAD beats, T TEXT beats, LEN.
    task automatic plan(input longint unsigned aad, input longint unsigned txt);
        longint unsigned a;
        longint unsigned t;
        logic [6:0]      la;
        logic [6:0]      lt;
        beat_t           b;
        a = blocks(aad);
        t = blocks(txt);
`ifdef GCM_SEQ_PARTIAL_BLOCK_EN
        la = 7'(aad % 128);
        lt = 7'(txt % 128);
`else
        la = 7'd0;
        lt = 7'd0;
`endif
        b.sz  = {aad[63:0], txt[63:0]};
        b.ph  = PH_HKEY;
        b.cnt = '0;
        b.nw  = 1'b1;
        b.lb  = 7'd0;
        exp_q.push_back(b);
        b.nw = 1'b0;
        for (longint unsigned k = 0; k < a; k++) begin
            b.ph  = PH_AAD;
            b.cnt = 128'(k);
            b.lb  = (k == a - 1) ? la : 7'd0;
            exp_q.push_back(b);
        end
        for (longint unsigned k = 0; k < t; k++) begin
            b.ph  = PH_TEXT;
            b.cnt = 128'(a + k);
            b.lb  = (k == t - 1) ? lt : 7'd0;
            exp_q.push_back(b);
        end
        b.ph  = PH_LEN;
        b.cnt = 128'(a + t);
        b.lb  = 7'd0;
        exp_q.push_back(b);
        n_started++;
    endtask

    // mode: 0 valid held high, 1 valid toggling, 2 random valid.
    // inj: pulse i_start (with a different size) once inside TEXT.
    // rst_mid: assert reset while AAD beat 1 is presented.
    task automatic run(input longint unsigned aad, input longint unsigned txt,
                       input int mode, input bit inj, input bit rst_mid);
        int guard;
        bit injected;
        bit toggle;
        plan(aad, txt);
        i_instance_size = {aad[63:0], txt[63:0]};
        i_start         = 1'b1;
        guard           = 0;
        injected        = 1'b0;
        toggle          = 1'b1;
        while ((n_closed != n_started) && (guard < GUARD_CYCLES)) begin
            @(posedge clk);
            #1;
            guard++;
            i_start = 1'b0;
            case (mode)
                0:       i_blk_valid = 1'b1;
                1: begin
                    i_blk_valid = toggle;
                    toggle      = ~toggle;
                end
                default: i_blk_valid = ($urandom_range(0, 9) < 7);
            endcase
            if (inj && !injected && (o_phase == PH_TEXT)) begin
                i_start         = 1'b1;
                i_instance_size = ~i_instance_size;
                injected        = 1'b1;
            end
            if (rst_mid && (o_phase == PH_AAD) && (o_counter == 128'd1)) begin
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        i_start = 1'b0;
        if (guard >= GUARD_CYCLES) begin
            to_cnt++;
            rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t got;
        beat_t want;
        logic  rdy_exp;
        logic  vld_exp;
        cyc++;
        if (seen_to != to_cnt) begin
            seen_to = to_cnt;
            checks++;
            errors++;
            $display("FAIL timeout: instance not finished, closed=%0d required=%0d", n_closed, n_started);
        end
        if (!rst_n) begin
            checks++;
            if ({o_valid, o_blk_ready, o_busy, o_done, o_new_instance} != 5'd0 ||
                o_phase != 3'd0 || o_last_bits != 7'd0 ||
                o_counter != '0 || o_instance_size != '0) begin
                errors++;
                $display("FAIL reset_zero: valid=%0b ready=%0b busy=%0b done=%0b new=%0b ph=%0d lb=%0d cnt=%0d sz=%h, required all 0",
                         o_valid, o_blk_ready, o_busy, o_done, o_new_instance, o_phase, o_last_bits, o_counter, o_instance_size);
            end
            exp_q.delete();
            n_closed = n_started;
        end else begin
            rdy_exp = (o_phase == PH_AAD) || (o_phase == PH_TEXT);
            vld_exp = (o_phase == PH_HKEY) || (o_phase == PH_LEN) || (rdy_exp && i_blk_valid);
            checks++;
            if (o_blk_ready != rdy_exp || o_valid != vld_exp || o_busy != (o_phase != PH_IDLE) ||
                o_done != (o_phase == PH_DONE) || o_new_instance != (o_phase == PH_HKEY)) begin
                errors++;
                $display("FAIL handshake: ph=%0d ready=%0b valid=%0b busy=%0b done=%0b new=%0b, required ready=%0b valid=%0b busy=%0b done=%0b new=%0b",
                         o_phase, o_blk_ready, o_valid, o_busy, o_done, o_new_instance,
                         rdy_exp, vld_exp, (o_phase != PH_IDLE), (o_phase == PH_DONE), (o_phase == PH_HKEY));
            end
            if (o_valid) begin
                got.ph  = o_phase;
                got.cnt = o_counter;
                got.nw  = o_new_instance;
                got.lb  = o_last_bits;
                got.sz  = o_instance_size;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got ph=%0d cnt=%0d, required no beat", got.ph, got.cnt);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL beat: got ph=%0d cnt=%0d new=%0b lb=%0d sz=%h, required ph=%0d cnt=%0d new=%0b lb=%0d sz=%h",
                                 got.ph, got.cnt, got.nw, got.lb, got.sz, want.ph, want.cnt, want.nw, want.lb, want.sz);
                    end
                end
                if (o_phase == PH_LEN) begin
                    len_cyc = cyc;
                end
            end
            if (o_done) begin
                checks++;
                if (n_closed >= n_started || exp_q.size() != 0 || (cyc - len_cyc) != PIPE_LATENCY) begin
                    errors++;
                    $display("FAIL done: open=%0d pending_beats=%0d latency=%0d, required open>0 pending_beats=0 latency=%0d",
                             n_started - n_closed, exp_q.size(), cyc - len_cyc, PIPE_LATENCY);
                end
                if (n_closed < n_started) begin
                    n_closed++;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(256, 384, 0, 1'b0, 1'b0);   // two AAD, three TEXT beats
        run(0, 128, 0, 1'b0, 1'b0);     // no AAD phase
        run(0, 1024, 1, 1'b0, 1'b0);    // valid toggling in TEXT
        run(128, 640, 2, 1'b1, 1'b0);   // i_start inside TEXT is ignored
        run(384, 128, 0, 1'b0, 1'b1);   // reset during AAD beat 1
        run(256, 128, 0, 1'b0, 1'b0);   // clean restart after reset
        run(0, 200, 0, 1'b0, 1'b0);     // partial text block
        run(0, 0, 0, 1'b0, 1'b0);       // HKEY straight to LEN
        run(300, 77, 2, 1'b0, 1'b0);    // partial blocks in both phases
        for (int i = 0; i < 8; i++) begin
            run(longint'($urandom_range(0, 1000)), longint'($urandom_range(0, 1000)), 2, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
